// File: rtl/pkt_ctl_pkg.sv
// Shared field widths, the packet-control word layout and its parity helper
// for the packet-control check/queue stage.
package pkt_ctl_pkg;

    localparam int PKT_PARITY_W  = 1;
    localparam int PKT_FLAGS_W   = 12;
    localparam int PKT_ADDR_W    = 20;
    localparam int PKT_W         = PKT_PARITY_W + PKT_FLAGS_W + PKT_ADDR_W;
    localparam int PKT_DEPTH_DEF = 4;
    localparam int PKT_CNT_W_DEF = 16;

    typedef struct packed {
        logic [PKT_PARITY_W-1:0] parity;
        logic [PKT_FLAGS_W-1:0]  flags;
        logic [PKT_ADDR_W-1:0]   addr;
    } pkt_ctl_t;

    // The parity bit is part of the reduction, so a good word XORs to the parity sense.
    function automatic logic pkt_par_ok(input pkt_ctl_t word, input logic odd);
        return (^word) == odd;
    endfunction

endpackage

// File: rtl/pkt_ctl_sync_fifo.sv
// Registered-array synchronous FIFO. Callers present only effective push/pop:
// push is never asserted while full unless pop is asserted in the same cycle.
module pkt_ctl_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; level gates its
    // visibility, and leaving it out of reset keeps it plain RAM-style flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == DEPTH[LVL_W-1:0]);
    assign empty   = (level == '0);

endmodule

// File: rtl/pkt_ctl_chk_queue.sv
// Parity-checks registered packet-control words and queues good ones for the
// forwarding engine; parity and FIFO-full drops are counted with saturation.
module pkt_ctl_chk_queue
    import pkt_ctl_pkg::*;
#(
    parameter int PARITY  = PKT_PARITY_W,
    parameter int FLAGS   = PKT_FLAGS_W,
    parameter int ADDR    = PKT_ADDR_W,
    parameter int DEPTH   = PKT_DEPTH_DEF,
    parameter int ODD_PAR = 0,
    parameter int CNT_W   = PKT_CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [PARITY+FLAGS+ADDR-1:0] pkt_ctl_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR-1:0]           out_addr,
    output logic [FLAGS-1:0]          out_flags,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_W-1:0]          par_err_cnt,
    output logic [CNT_W-1:0]          ovf_cnt
);

    localparam int DATA_W = FLAGS + ADDR;

    if (PARITY != 1) begin : g_bad_parity_w
        $error("pkt_ctl_chk_queue: only PARITY=1 is supported");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pkt_ctl_chk_queue: DEPTH must be a power of two and >= 2");
    end

    logic par_good;
    logic push_ok;
    logic pop;
    logic push;
    logic full;
    logic empty;
    logic par_drop;
    logic ovf_drop;
    logic [DATA_W-1:0] rd_data;

    if (PARITY == PKT_PARITY_W && FLAGS == PKT_FLAGS_W && ADDR == PKT_ADDR_W) begin : g_par_pkg
        assign par_good = pkt_par_ok(pkt_ctl_t'(pkt_ctl_data), ODD_PAR != 0);
    end else begin : g_par_generic
        assign par_good = ((^pkt_ctl_data) == (ODD_PAR != 0));
    end

    assign out_valid = !empty;
    assign pop       = out_valid & out_ready;
    assign push_ok   = in_valid & par_good;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = push_ok & (!full | pop);
    assign par_drop  = in_valid & !par_good;
    assign ovf_drop  = push_ok & full & !pop;

    pkt_ctl_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (pkt_ctl_data[DATA_W-1:0]),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign out_addr  = rd_data[ADDR-1:0];
    assign out_flags = rd_data[ADDR +: FLAGS];

    always_ff @(posedge clk) begin
        if (rst)                                 par_err_cnt <= '0;
        else if (par_drop && par_err_cnt != '1)  par_err_cnt <= par_err_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                                 ovf_cnt <= '0;
        else if (ovf_drop && ovf_cnt != '1)      ovf_cnt <= ovf_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pkt_ctl_chk_queue.sv
// Randomised and directed bench for pkt_ctl_chk_queue with a queue-based
// reference model and a decoupled output monitor.
module tb_pkt_ctl_chk_queue;

    localparam int ADDR    = 20;
    localparam int FLAGS   = 12;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int ODD_PAR = 0;
    localparam int W       = 1 + FLAGS + ADDR;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic [W-1:0]           pkt_ctl_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [ADDR-1:0]        out_addr;
    logic [FLAGS-1:0]       out_flags;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       par_err_cnt;
    logic [CNT_W-1:0]       ovf_cnt;

    pkt_ctl_chk_queue #(
        .PARITY(1), .FLAGS(FLAGS), .ADDR(ADDR),
        .DEPTH(DEPTH), .ODD_PAR(ODD_PAR), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .pkt_ctl_data (pkt_ctl_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_flags    (out_flags),
        .level        (level),
        .par_err_cnt  (par_err_cnt),
        .ovf_cnt      (ovf_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [FLAGS+ADDR-1:0] exp_q[$];
    int mlevel = 0;
    int mpar   = 0;
    int movf   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] mk_word(input logic [ADDR-1:0] a,
                                              input logic [FLAGS-1:0] f,
                                              input bit corrupt);
        logic p;
        p = (^{f, a}) ^ (ODD_PAR != 0) ^ corrupt;
        return {p, f, a};
    endfunction

    // Monitor: every accepted head must match the oldest word the model queued,
    // and a stalled head must stay put.
    logic                  hold_prev = 1'b0;
    logic [FLAGS+ADDR-1:0] prev_data;
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'({out_flags, out_addr}), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 64'({out_flags, out_addr}), 64'hDEAD);
                else check("out_data", 64'({out_flags, out_addr}), 64'(exp_q.pop_front()));
            end
            hold_prev = out_valid && !out_ready;
            prev_data = {out_flags, out_addr};
        end
    end

    task automatic check_state(input string tag);
        check({tag, "_level"}, 64'(level), 64'(mlevel));
        check({tag, "_valid"}, 64'(out_valid), 64'(mlevel > 0));
        check({tag, "_par"},   64'(par_err_cnt), 64'(mpar));
        check({tag, "_ovf"},   64'(ovf_cnt), 64'(movf));
    endtask

    // One clock: drive at posedge+1, advance the model, check after the next edge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit r);
        bit do_pop;
        in_valid     = v;
        pkt_ctl_data = d;
        out_ready    = r;
        do_pop = (mlevel > 0) && r;
        if (v) begin
            if ((^d) != (ODD_PAR != 0)) begin
                if (mpar < CNT_MAX) mpar++;
            end else if (mlevel < DEPTH || do_pop) begin
                exp_q.push_back(d[FLAGS+ADDR-1:0]);
                mlevel++;
            end else if (movf < CNT_MAX) begin
                movf++;
            end
        end
        if (do_pop) mlevel--;
        @(posedge clk);
        #1;
        check_state("step");
    endtask

    task automatic do_reset(input bit v, input logic [W-1:0] d);
        rst          = 1'b1;
        in_valid     = v;
        pkt_ctl_data = d;
        out_ready    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mlevel = 0;
        mpar   = 0;
        movf   = 0;
        check_state("reset");
    endtask

    logic [W-1:0] w;

    initial begin
        do_reset(1'b0, '0);

        // Single good word, ready high: visible one cycle later, then drained.
        step(1'b1, mk_word(20'h12345, 12'h0A5, 1'b0), 1'b1);
        check("t1_addr", 64'(out_addr), 64'h12345);
        check("t1_flags", 64'(out_flags), 64'h0A5);
        step(1'b0, '0, 1'b1);

        // Same word with parity flipped.
        step(1'b1, mk_word(20'h12345, 12'h0A5, 1'b1), 1'b1);
        check("t2_par", 64'(par_err_cnt), 64'd1);
        step(1'b0, '0, 1'b1);

        // Six good words into a stalled FIFO, then drain.
        for (int i = 0; i < 6; i++)
            step(1'b1, mk_word(20'(32'hA0000 + i), 12'(i), 1'b0), 1'b0);
        check("t3_level", 64'(level), 64'd4);
        check("t3_ovf", 64'(ovf_cnt), 64'd2);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1);

        // Full FIFO with simultaneous pop and push.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, mk_word(20'(32'hB0000 + i), 12'(32'h100 + i), 1'b0), 1'b0);
        step(1'b1, mk_word(20'hB00FF, 12'h1FF, 1'b0), 1'b1);
        check("t4_level", 64'(level), 64'd4);
        check("t4_ovf", 64'(ovf_cnt), 64'd2);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1);

        // Drive the parity counter past its ceiling.
        for (int i = 0; i < CNT_MAX + 2; i++)
            step(1'b1, mk_word(20'($urandom), 12'($urandom), 1'b1), 1'b1);
        check("t5_par_sat", 64'(par_err_cnt), 64'(CNT_MAX));

        // Reset with three entries held and a word arriving.
        for (int i = 0; i < 3; i++)
            step(1'b1, mk_word(20'(32'hC0000 + i), 12'h3C, 1'b0), 1'b0);
        do_reset(1'b1, mk_word(20'hC00AA, 12'h3C, 1'b0));
        check("t6_level", 64'(level), 64'd0);
        step(1'b1, mk_word(20'h0BEEF, 12'h777, 1'b0), 1'b1);
        step(1'b0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            w = mk_word(20'($urandom), 12'($urandom), $urandom_range(0, 4) == 0);
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
